imu_spi_responder: RTL and testbench
====================================

// Module: imu_spi_responder
// PURPOSE
//  SPI slave modelling the IMU side of the register-read protocol: decodes the 32-bit request
//  header {8'h01, reg_idx, 16'h0}, then serves consecutive 32-bit words on miso in the next cs frame.
//  Used as an IMU emulator for loopback/bench bring-up of the IMU read path. Word data is fetched from host logic.
// PARAMETERS
//  W            32     SPI word width, bits; MSB first
//  SYNC_STAGES  2      flops synchronising cs/sck/mosi into c
//  TIMEOUT_CNT  25000  armed-state timeout in c cycles (200us @125MHz); used only with IMU_RESP_TIMEOUT_EN
// PORTS
//  c           in   1   clock
//  rst_n       in   1   async reset, active low
//  cs          in   1   SPI chip select, active low (async to c)
//  sck         in   1   SPI clock, idle low (async to c)
//  mosi        in   1   SPI data from master
//  miso        out  1   SPI data to master, registered
//  req_dv      out  1   1-cycle pulse: valid header decoded
//  req_idx     out  8   header bits[23:16]; held until next valid header
//  rd_en       out  1   1-cycle word fetch strobe
//  rd_addr     out  5   word index for rd_en
//  rd_d        in   W   word data; sampled exactly 1 cycle after rd_en
//  resp_done   out  1   1-cycle pulse: response frame ended (cs rose)
//  resp_words  out  6   complete words shifted in last response frame, saturates at 63
//  err         out  1   1-cycle pulse: bad header, short header frame, or timeout
//  busy        out  1   high in any state except IDLE
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, shifter/prefetch cleared. Async assert, sync deassert via c.
//  - SPI mode 0: master samples on sck rise; responder samples mosi on synced sck rise, updates miso on synced
//    sck fall. Edge detect on the last sync stage; miso valid <=SYNC_STAGES+1 cycles after pin edge;
//    sck half-period must be >=4 c cycles. sck edges ignored while synced cs high; cs edge wins same cycle.
//  - States: IDLE, RX_REQ, ARMED, TX_RESP.
//  - IDLE: cs fall -> RX_REQ, bit_cnt=0. miso=0.
//  - RX_REQ: shift mosi on each sck rise. cs rise with bit_cnt==W: if bits[31:24]==8'h01 -> latch req_idx,
//    req_dv pulse, rd_en with rd_addr=0 same cycle, ARMED; else err pulse, IDLE. cs rise with bit_cnt!=W:
//    err, IDLE. Extra bits beyond W: only last W kept.
//  - ARMED: prefetch buffer holds rd_d(addr 0). cs fall -> load buffer into shifter, miso=MSB,
//    rd_en addr 1, TX_RESP, word counter 0.
//  - TX_RESP: bit_cnt counts sck rises. On sck fall: if bit_cnt==W -> load prefetch into shifter, miso=MSB,
//    bit_cnt=0, resp_words++, rd_en addr+1; else shift left. mosi ignored. rd_addr 5-bit, wraps 31->0.
//    cs rise -> resp_done pulse, resp_words final (partial word not counted), IDLE, miso=0.
//  - rd_en never issued more than once per word; prefetch loaded 1 cycle after rd_en, before next use.
//  - Reset mid-operation: immediate return to IDLE, miso=0, no resp_done/err pulse.
// CONFIGURATION
//  IMU_RESP_TIMEOUT_EN defined: counter runs in ARMED; at TIMEOUT_CNT cycles without cs fall -> err pulse,
//  IDLE. Counter cleared on entering ARMED.
//  Undefined: no counter, ARMED held indefinitely until cs fall or reset.
// TESTING
//  1. Header 32'h012A0000, cs high 100us, 4-word frame, rd_d=32'hA5000000+addr -> req_dv, req_idx=8'h2A,
//     miso words A5000000..A5000003, resp_done with resp_words=4.
//  2. Header 32'h02100000 -> err pulse, no req_dv, next frame miso all 0, busy=0 after cs rise.
//  3. cs rises after 20 header bits -> err pulse, state IDLE, req_idx unchanged.
//  4. rst_n low during word 2 of response -> miso=0, busy=0 same cycle; fresh header afterwards decodes normally.
//  5. IMU_RESP_TIMEOUT_EN, TIMEOUT_CNT=100: header then no cs for 101 cycles -> err, IDLE; macro off -> stays ARMED.
//  6. 33-word response -> rd_addr wraps 31->0, word 32 equals rd_d(addr 0), resp_words=33.

Source files
------------

// File: rtl/imu_spi_responder.sv
// imu_spi_responder: SPI-slave IMU emulator that decodes a read header and streams prefetched host words.
// Define IMU_RESP_TIMEOUT_EN to drop an ARMED request after TIMEOUT_CNT cycles without a response frame.
module imu_spi_responder #(
    parameter int W           = 32,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CNT = 25000
) (
    input  logic         c,
    input  logic         rst_n,
    input  logic         cs,
    input  logic         sck,
    input  logic         mosi,
    output logic         miso,
    output logic         req_dv,
    output logic [7:0]   req_idx,
    output logic         rd_en,
    output logic [4:0]   rd_addr,
    input  logic [W-1:0] rd_d,
    output logic         resp_done,
    output logic [5:0]   resp_words,
    output logic         err,
    output logic         busy
);
    localparam int BW = $clog2(W + 1);
    localparam logic [BW-1:0] W_CNT = BW'(W);

    typedef enum logic [1:0] {IDLE, RX_REQ, ARMED, TX_RESP} state_t;

    logic [1:0] rst_sync_q, rst_sync_d;
    logic rst_ni;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d, sck_sync_q, sck_sync_d, mosi_sync_q, mosi_sync_d;
    logic cs_prev_q, sck_prev_q, cs_s, sck_s, mosi_s, cs_fall, cs_rise, sck_rise, sck_fall;
    state_t state_q, state_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d, bit_inc;
    logic [W-1:0] shift_q, shift_d, pre_q, pre_d;
    logic fetch_q, miso_q, miso_d, req_dv_q, req_dv_d, rd_en_q, rd_en_d;
    logic resp_done_q, resp_done_d, err_q, err_d;
    logic [7:0] req_idx_q, req_idx_d;
    logic [4:0] rd_addr_q, rd_addr_d;
    logic [5:0] wcnt_q, wcnt_d, wcnt_inc, resp_words_q, resp_words_d;

    always_comb begin
        rst_sync_d  = {rst_sync_q[0], 1'b1};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], sck};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    end

    always_ff @(posedge c or negedge rst_n)
        if (!rst_n) rst_sync_q <= '0;
        else        rst_sync_q <= rst_sync_d;

    assign rst_ni   = rst_sync_q[1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign cs_fall  = cs_prev_q & ~cs_s;
    assign cs_rise  = ~cs_prev_q & cs_s;
    // sck edges only count while cs has been low for two samples, so a cs edge always wins
    assign sck_rise = ~cs_s & ~cs_prev_q & sck_s & ~sck_prev_q;
    assign sck_fall = ~cs_s & ~cs_prev_q & ~sck_s & sck_prev_q;
    assign bit_inc  = (bit_cnt_q == W_CNT) ? bit_cnt_q : bit_cnt_q + BW'(1);
    assign wcnt_inc = (wcnt_q == 6'd63) ? wcnt_q : wcnt_q + 6'd1;

`ifdef IMU_RESP_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CNT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CNT - 1);
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    assign to_cnt_d = (state_q == ARMED) ? to_cnt_q + TW'(1) : '0;
    always_ff @(posedge c or negedge rst_ni)
        if (!rst_ni) to_cnt_q <= '0;
        else         to_cnt_q <= to_cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = TIMEOUT_CNT != 0;
`endif

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        pre_d        = fetch_q ? rd_d : pre_q;
        miso_d       = miso_q;
        req_dv_d     = 1'b0;
        req_idx_d    = req_idx_q;
        rd_en_d      = 1'b0;
        rd_addr_d    = rd_addr_q;
        resp_done_d  = 1'b0;
        resp_words_d = resp_words_q;
        err_d        = 1'b0;
        wcnt_d       = wcnt_q;
        case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                if (cs_fall) begin
                    state_d   = RX_REQ;
                    bit_cnt_d = '0;
                end
            end
            RX_REQ: begin
                if (cs_rise) begin
                    if (bit_cnt_q == W_CNT && shift_q[W-1 -: 8] == 8'h01) begin
                        req_idx_d = shift_q[W-9 -: 8];
                        req_dv_d  = 1'b1;
                        rd_en_d   = 1'b1;
                        rd_addr_d = '0;
                        state_d   = ARMED;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end else if (sck_rise) begin
                    shift_d   = {shift_q[W-2:0], mosi_s};
                    bit_cnt_d = bit_inc;
                end
            end
            ARMED: begin
                if (cs_fall) begin
                    shift_d   = pre_q;
                    miso_d    = pre_q[W-1];
                    rd_en_d   = 1'b1;
                    rd_addr_d = 5'd1;
                    bit_cnt_d = '0;
                    wcnt_d    = '0;
                    state_d   = TX_RESP;
                end
`ifdef IMU_RESP_TIMEOUT_EN
                else if (to_cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
`endif
            end
            TX_RESP: begin
                if (cs_rise) begin
                    resp_done_d  = 1'b1;
                    resp_words_d = (bit_cnt_q == W_CNT) ? wcnt_inc : wcnt_q;
                    miso_d       = 1'b0;
                    state_d      = IDLE;
                end else if (sck_rise) begin
                    bit_cnt_d = bit_inc;
                end else if (sck_fall) begin
                    if (bit_cnt_q == W_CNT) begin
                        shift_d   = pre_q;
                        miso_d    = pre_q[W-1];
                        bit_cnt_d = '0;
                        wcnt_d    = wcnt_inc;
                        rd_en_d   = 1'b1;
                        rd_addr_d = rd_addr_q + 5'd1;
                    end else begin
                        shift_d = shift_q << 1;
                        miso_d  = shift_q[W-2];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge c or negedge rst_ni) begin
        if (!rst_ni) begin
            cs_sync_q    <= '1;
            sck_sync_q   <= '0;
            mosi_sync_q  <= '0;
            cs_prev_q    <= 1'b1;
            sck_prev_q   <= 1'b0;
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            pre_q        <= '0;
            fetch_q      <= 1'b0;
            miso_q       <= 1'b0;
            req_dv_q     <= 1'b0;
            req_idx_q    <= '0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            resp_done_q  <= 1'b0;
            resp_words_q <= '0;
            err_q        <= 1'b0;
            wcnt_q       <= '0;
        end else begin
            cs_sync_q    <= cs_sync_d;
            sck_sync_q   <= sck_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            cs_prev_q    <= cs_s;
            sck_prev_q   <= sck_s;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            pre_q        <= pre_d;
            fetch_q      <= rd_en_q;
            miso_q       <= miso_d;
            req_dv_q     <= req_dv_d;
            req_idx_q    <= req_idx_d;
            rd_en_q      <= rd_en_d;
            rd_addr_q    <= rd_addr_d;
            resp_done_q  <= resp_done_d;
            resp_words_q <= resp_words_d;
            err_q        <= err_d;
            wcnt_q       <= wcnt_d;
        end
    end

    assign miso       = miso_q;
    assign req_dv     = req_dv_q;
    assign req_idx    = req_idx_q;
    assign rd_en      = rd_en_q;
    assign rd_addr    = rd_addr_q;
    assign resp_done  = resp_done_q;
    assign resp_words = resp_words_q;
    assign err        = err_q;
    assign busy       = state_q != IDLE;
endmodule

// File: tb/tb_imu_spi_responder.sv
// tb_imu_spi_responder: randomized SPI master plus word-level reference for the IMU responder.
module tb_imu_spi_responder;
    localparam int HALF    = 6;
    localparam int ARM_GAP = 30;

    logic c = 1'b0, rst_n = 1'b0, cs = 1'b1, sck = 1'b0, mosi = 1'b0;
    logic miso, req_dv, rd_en, resp_done, err, busy;
    logic [7:0] req_idx;
    logic [4:0] rd_addr;
    logic [5:0] resp_words;
    logic [31:0] rd_d = '0;
    logic [31:0] base = '0;

    int checks = 0, errors = 0;
    int n_dv = 0, n_err = 0, n_done = 0;
    logic [4:0] addr_q[$];

    always #5 c = ~c;

    imu_spi_responder #(.W(32), .SYNC_STAGES(2), .TIMEOUT_CNT(100)) dut (
        .c(c), .rst_n(rst_n), .cs(cs), .sck(sck), .mosi(mosi), .miso(miso),
        .req_dv(req_dv), .req_idx(req_idx), .rd_en(rd_en), .rd_addr(rd_addr), .rd_d(rd_d),
        .resp_done(resp_done), .resp_words(resp_words), .err(err), .busy(busy)
    );

    // host register file: answers a fetch one cycle after the strobe
    always @(posedge c) if (rd_en) rd_d <= base + 32'(rd_addr);

    always @(negedge c) begin
        if (req_dv) n_dv++;
        if (err) n_err++;
        if (resp_done) n_done++;
        if (rd_en) addr_q.push_back(rd_addr);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge c);
    endtask

    function automatic logic [31:0] exp_word(input int k);
        return base + 32'(k % 32);
    endfunction

    task automatic send_hdr(input logic [31:0] hdr, input int nb);
        cs = 1'b0;
        wait_cyc(HALF);
        for (int j = 0; j < nb; j++) begin
            if (nb < 32) mosi = hdr[31-j];
            else if (j < nb - 32) mosi = 1'($urandom);
            else mosi = hdr[31-(j-(nb-32))];
            wait_cyc(HALF);
            sck = 1'b1;
            wait_cyc(HALF);
            sck = 1'b0;
        end
        wait_cyc(HALF);
        cs = 1'b1;
        wait_cyc(12);
    endtask

    task automatic rx_frame(input int nwords, input int extra, input bit zero, input int abort_at);
        logic [31:0] w;
        int nb;
        w  = '0;
        nb = nwords * 32 + extra;
        cs = 1'b0;
        wait_cyc(HALF);
        for (int j = 0; j < nb; j++) begin
            if (j == abort_at) begin
                rst_n = 1'b0;
                #1;
                check("abort miso", 32'(miso), 32'd0);
                check("abort busy", 32'(busy), 32'd0);
                wait_cyc(3);
                cs    = 1'b1;
                sck   = 1'b0;
                rst_n = 1'b1;
                wait_cyc(10);
                return;
            end
            mosi = zero ? 1'b0 : 1'($urandom);
            wait_cyc(HALF);
            w = {w[30:0], miso};
            sck = 1'b1;
            wait_cyc(HALF);
            sck = 1'b0;
            if (j % 32 == 31) check($sformatf("word%0d", j / 32), w, zero ? 32'd0 : exp_word(j / 32));
        end
        wait_cyc(HALF);
        cs = 1'b1;
        wait_cyc(12);
    endtask

    task automatic do_read(input logic [7:0] idx, input int nw, input int partial, input int hx);
        int dv0, e0, d0;
        dv0 = n_dv;
        e0  = n_err;
        d0  = n_done;
        addr_q.delete();
        send_hdr({8'h01, idx, 16'h0}, 32 + hx);
        check("req_dv", 32'(n_dv - dv0), 32'd1);
        check("req_idx", 32'(req_idx), 32'(idx));
        check("busy armed", 32'(busy), 32'd1);
        wait_cyc(ARM_GAP);
        rx_frame(nw, partial, 1'b0, -1);
        check("resp_done", 32'(n_done - d0), 32'd1);
        check("no err", 32'(n_err - e0), 32'd0);
        check("resp_words", 32'(resp_words), 32'(nw > 63 ? 63 : nw));
        check("busy idle", 32'(busy), 32'd0);
        check("rd count", 32'(addr_q.size()), 32'(nw + 2));
        for (int i = 0; i < addr_q.size(); i++) check("rd_addr", 32'(addr_q[i]), 32'(i % 32));
    endtask

    initial begin
        int dv0, e0, d0;
        wait_cyc(4);
        check("rst miso", 32'(miso), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst req_dv", 32'(req_dv), 32'd0);
        check("rst rd_en", 32'(rd_en), 32'd0);
        check("rst err", 32'(err), 32'd0);
        check("rst resp_done", 32'(resp_done), 32'd0);
        check("rst resp_words", 32'(resp_words), 32'd0);
        check("rst req_idx", 32'(req_idx), 32'd0);
        rst_n = 1'b1;
        wait_cyc(6);

        base = 32'hA500_0000;
        do_read(8'h2A, 4, 0, 0);

        dv0 = n_dv; e0 = n_err;
        send_hdr(32'h0210_0000, 32);
        check("bad hdr err", 32'(n_err - e0), 32'd1);
        check("bad hdr dv", 32'(n_dv - dv0), 32'd0);
        check("bad hdr busy", 32'(busy), 32'd0);
        rx_frame(1, 0, 1'b1, -1);
        check("zero frame busy", 32'(busy), 32'd0);

        dv0 = n_dv; e0 = n_err;
        send_hdr(32'h0177_0000, 20);
        check("short err", 32'(n_err - e0), 32'd1);
        check("short dv", 32'(n_dv - dv0), 32'd0);
        check("short req_idx", 32'(req_idx), 32'h2A);
        check("short busy", 32'(busy), 32'd0);

        base = $urandom;
        send_hdr(32'h015C_0000, 32);
        wait_cyc(ARM_GAP);
        e0 = n_err; d0 = n_done;
        rx_frame(3, 0, 1'b0, 40);
        check("abort no err", 32'(n_err - e0), 32'd0);
        check("abort no done", 32'(n_done - d0), 32'd0);
        do_read(8'h33, 2, 5, 3);

        e0 = n_err;
        send_hdr(32'h0111_0000, 32);
`ifdef IMU_RESP_TIMEOUT_EN
        wait_cyc(110);
        check("timeout err", 32'(n_err - e0), 32'd1);
        check("timeout busy", 32'(busy), 32'd0);
`else
        wait_cyc(300);
        check("armed held err", 32'(n_err - e0), 32'd0);
        check("armed held busy", 32'(busy), 32'd1);
        rx_frame(1, 0, 1'b0, -1);
        check("armed held done", 32'(busy), 32'd0);
`endif

        for (int t = 0; t < 6; t++) begin
            base = $urandom;
            do_read(8'($urandom), $urandom_range(1, 4), $urandom_range(0, 31), $urandom_range(0, 6));
        end

        base = $urandom;
        do_read(8'h9E, 33, 0, 0);
        base = $urandom;
        do_read(8'h41, 64, 7, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
